// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 fetch stage: PC, imem requests, in-order buffer, redirect drain
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  fetch_unit_if.master        imem,
  input  logic                redirect_i,
  input  logic [31:0]         redirect_pc_i,
  input  logic                stall_i,
  output logic                instr_valid_o,
  output logic [31:0]         instruction_o,
  output logic [31:0]         pc_o
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] kill_q, kill_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [31:0]      fifo_pc_q   [FIFO_DEPTH];

  logic             req_w;
  logic             grant_w;
  logic             rsp_w;
  logic             fifo_wr_w;
  logic             pop_w;
  logic [CNT_W-1:0] inflight_w;
  logic [CNT_W:0]   credit_used_w;
  logic [31:0]      target_w;

  // Handshake qualifiers shared by the FSM and the datapath
  always_comb begin
    credit_used_w = {1'b0, occ_q} + {1'b0, out_q};
    grant_w       = req_w && imem.gnt;
    rsp_w         = imem.rvalid;
    fifo_wr_w     = (state_q == FETCH) && rsp_w && !redirect_i;
    pop_w         = (occ_q != '0) && !stall_i && !redirect_i;
    // Requests still owed a response after this cycle; any of them is wrong-path on redirect
    inflight_w    = out_q - CNT_W'(rsp_w) + CNT_W'(grant_w);
    target_w      = {redirect_pc_i[31:2], 2'b00};
  end

  // FSM state and kill counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      kill_q  <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // FSM next state: drain wrong-path responses after a redirect with requests in flight
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (redirect_i && (inflight_w != '0)) begin
          state_d = DRAIN;
          kill_d  = inflight_w;
        end
      end
      DRAIN: begin
        kill_d = kill_q - CNT_W'(rsp_w);
        if (kill_d == '0) state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase
  end

  // FSM outputs: request gated by credit, buffer head presented downstream
  always_comb begin
    req_w         = (state_q == FETCH) && !redirect_i && (credit_used_w < DEPTH_C);
    instr_valid_o = (occ_q != '0);
    instruction_o = instr_valid_o ? fifo_data_q[rd_ptr_q] : NOP;
    pc_o          = instr_valid_o ? fifo_pc_q[rd_ptr_q] : 32'h0;
  end

  assign imem.req  = req_w;
  assign imem.addr = pc_q;

  // Datapath next state; redirect overrides PC and flushes the buffer
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    out_d    = out_q + CNT_W'(grant_w) - CNT_W'(rsp_w);
    if (redirect_i) begin
      pc_d     = target_w;
      rsp_pc_d = target_w;
      occ_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (grant_w) pc_d = pc_q + 32'd4;
      if (fifo_wr_w) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop_w) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      occ_d = occ_q + CNT_W'(fifo_wr_w) - CNT_W'(pop_w);
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      occ_q    <= '0;
      out_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      occ_q    <= occ_d;
      out_q    <= out_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Buffer storage; contents are meaningless while occupancy excludes them
  always_ff @(posedge clk_i) begin
    if (fifo_wr_w) begin
      fifo_data_q[wr_ptr_q] <= imem.rdata;
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end
endmodule
